// File: rtl/io_rx_controller.sv
// Image SRAM geometry and control bundle shared by the SRAM-side controllers,
// plus the raster-order receive controller that writes the incoming byte stream.
package img_sram_pkg;
    typedef struct packed {
        logic       sense_en;   // active-low read sensing; held inactive by writers
        logic       write_en;
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] din;
    } img_sram_ctrl_t;
endpackage

// io_rx_controller: accepts one pixel byte per valid/ready transfer and writes
// it to the image SRAM one cycle later, row-major from (0,0).
module io_rx_controller
    import img_sram_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    input  logic [7:0]     din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic           busy,
    output logic           done,
    output img_sram_ctrl_t sram_ctrl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] nrows_q, nrows_d;
    logic [7:0] ncols_q, ncols_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic       wr_pend_q, wr_pend_d;
    logic [7:0] wr_row_q, wr_row_d;
    logic [7:0] wr_col_q, wr_col_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic       xfer;
    logic       last_col;
    logic       last_row;

    assign din_ready = (state_q == RECV);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign xfer      = din_valid & din_ready;
    assign last_col  = (col_q == (ncols_q - 8'd1));
    assign last_row  = (row_q == (nrows_q - 8'd1));

    // SRAM port is driven straight from the one-deep write stage
    always_comb begin
        sram_ctrl.sense_en = 1'b1;
        sram_ctrl.write_en = wr_pend_q;
        sram_ctrl.row      = wr_row_q;
        sram_ctrl.col      = wr_col_q;
        sram_ctrl.din      = wr_data_q;
    end

    // Next-state: frame sequencing, raster index advance and write-stage capture
    always_comb begin
        state_d   = state_q;
        nrows_d   = nrows_q;
        ncols_d   = ncols_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_pend_d = xfer;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (nrows != 8'd0 && ncols != 8'd0) begin
                        nrows_d = nrows;
                        ncols_d = ncols;
                        row_d   = 8'd0;
                        col_d   = 8'd0;
                        state_d = RECV;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RECV: begin
                if (xfer) begin
                    wr_row_d  = row_q;
                    wr_col_d  = col_q;
                    wr_data_d = din;
                    if (!last_col) begin
                        col_d = col_q + 8'd1;
                    end else if (!last_row) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                    end else begin
                        // final pixel: park indices at 0 so they never step past the frame
                        col_d   = 8'd0;
                        row_d   = 8'd0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            nrows_q   <= 8'd0;
            ncols_q   <= 8'd0;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            wr_pend_q <= 1'b0;
            wr_row_q  <= 8'd0;
            wr_col_q  <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            nrows_q   <= nrows_d;
            ncols_q   <= ncols_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_pend_q <= wr_pend_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule
